stage_sequencer: RTL

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/seq_pkg.sv | 7 +
 rtl/stage_watchdog.sv | 22 ++
 rtl/stage_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and default acknowledge timeout shared by stage_sequencer and stage_watchdog
package seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_ERROR
    } seq_state_e;
    localparam int SEQ_TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/stage_watchdog.sv
// stage_watchdog: per-state wait counter, cleared on state entry, flags timeout on the last allowed waiting cycle
module stage_watchdog
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       waiting,
    output logic [7:0] cnt,
    output logic       timeout
);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? 8'd0 : waiting ? cnt_q + 8'd1 : cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 8'd0;
        else       cnt_q <= cnt_d;
    end
    assign cnt     = cnt_q;
    assign timeout = waiting && cnt_q == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: FETCH/DECODE/EXEC/MEM/WB go/ack sequencer with halt and ack timeout.
// Defining SEQ_PERF_CNT_EN adds retired_cnt and cycle_cnt outputs.
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    input  logic        IF_kick_up,
    input  logic        ID_kick_up,
    input  logic        EX_kick_up,
    input  logic        MEM_kick_up,
    input  logic        WB_kick_up,
    input  logic        Controller_memaccess,
    output logic        fetch_go,
    output logic        decode_go,
    output logic        exec_go,
    output logic        mem_go,
    output logic        wb_go,
    output logic        pc_update,
    output logic        busy,
    output logic        seq_error,
    output logic [2:0]  seq_state
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] cycle_cnt
`endif
);
    seq_state_e state_q, state_d;
    logic       halt_q, halt_d, mem_q, mem_d;
    logic       stage, ack, waiting, clr, timeout, first;
    logic [7:0] wait_cnt;

    assign stage   = state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
    assign ack     = (state_q == S_FETCH  && IF_kick_up)  || (state_q == S_DECODE && ID_kick_up) ||
                     (state_q == S_EXEC   && EX_kick_up)  || (state_q == S_MEM    && MEM_kick_up) ||
                     (state_q == S_WB     && WB_kick_up);
    assign waiting = stage && !ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = halt_req ? S_HALTED : start ? S_FETCH : S_IDLE;
            S_FETCH:  state_d = timeout ? S_ERROR : ack ? S_DECODE : S_FETCH;
            S_DECODE: state_d = timeout ? S_ERROR : ack ? S_EXEC : S_DECODE;
            S_EXEC:   state_d = timeout ? S_ERROR : ack ? (mem_q ? S_MEM : S_WB) : S_EXEC;
            S_MEM:    state_d = timeout ? S_ERROR : ack ? S_WB : S_MEM;
            S_WB:     state_d = timeout ? S_ERROR : ack ? ((halt_q || halt_req) ? S_HALTED : S_FETCH) : S_WB;
            default:  state_d = state_q;
        endcase
        clr    = state_d != state_q;
        halt_d = (state_d == S_HALTED) ? 1'b0 : (halt_q || halt_req);
        mem_d  = (state_q == S_DECODE && ID_kick_up) ? Controller_memaccess : mem_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            halt_q  <= 1'b0;
            mem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
            mem_q   <= mem_d;
        end
    end

    stage_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (clr),
        .waiting (waiting),
        .cnt     (wait_cnt),
        .timeout (timeout)
    );

    // The wait counter is zero only in the entry cycle of a stage, so it doubles as the go strobe.
    assign first     = wait_cnt == 8'd0;
    assign fetch_go  = state_q == S_FETCH  && first;
    assign decode_go = state_q == S_DECODE && first;
    assign exec_go   = state_q == S_EXEC   && first;
    assign mem_go    = state_q == S_MEM    && first;
    assign wb_go     = state_q == S_WB     && first;
    assign pc_update = state_q == S_WB && WB_kick_up && !reset;
    assign busy      = stage;
    assign seq_error = state_q == S_ERROR;
    assign seq_state = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt_q, retired_cnt_d, cycle_cnt_q, cycle_cnt_d;
    always_comb begin
        retired_cnt_d = retired_cnt_q + {31'd0, pc_update};
        cycle_cnt_d   = cycle_cnt_q + {31'd0, busy};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_cnt_q <= 32'd0;
            cycle_cnt_q   <= 32'd0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            cycle_cnt_q   <= cycle_cnt_d;
        end
    end
    assign retired_cnt = retired_cnt_q;
    assign cycle_cnt   = cycle_cnt_q;
`endif
endmodule
